// File: rtl/guess_game_n.sv
// guess_game_n: rotating-LED reaction game with wrap/bounce rotation, score and lives.
module guess_game_n #(
  parameter int N       = 4,
  parameter int SCORE_W = 4,
  parameter int LIVES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       b,
  output logic [N-1:0]       y,
  output logic               win,
  output logic               lose,
  output logic               over,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives_left
);
  typedef enum logic [1:0] {SPIN, WIN, LOSE, OVER} state_t;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SPIN;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end
  // dir_q: 0 = moving up, 1 = moving down; a press always beats an en advance
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      SPIN:
        if (|b) begin
          if (b == y) begin
            state_d = WIN;
            score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          end else begin
            state_d = LOSE;
            lives_d = (lives_q == '0) ? lives_q : lives_q - 1'b1;
          end
        end else if (en) begin
          if (!mode) begin
            pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
            dir_d = 1'b0;
          end else if (!dir_q) begin
            pos_d = (pos_q == LAST) ? LAST - 1'b1 : pos_q + 1'b1;
            dir_d = (pos_q == LAST);
          end else begin
            pos_d = (pos_q == '0) ? PW'(1) : pos_q - 1'b1;
            dir_d = (pos_q != '0);
          end
        end
      WIN:
        if (!(|b)) begin
          state_d = SPIN;
          pos_d   = '0;
          dir_d   = 1'b0;
        end
      LOSE:
        if (!(|b)) begin
          state_d = (lives_q == '0) ? OVER : SPIN;
          pos_d   = '0;
          dir_d   = 1'b0;
        end
      default: ;
    endcase
  end
  always_comb begin
    y          = (state_q == SPIN) ? (N'(1) << pos_q) : (state_q == WIN) ? '1 : '0;
    win        = (state_q == WIN);
    lose       = (state_q == LOSE) || (state_q == OVER);
    over       = (state_q == OVER);
    score      = score_q;
    lives_left = lives_q;
  end
endmodule

// File: tb/tb_guess_game_n.sv
// tb_guess_game_n: table-driven directed check of guess_game_n (default params plus SCORE_W=1 copy).
module tb_guess_game_n;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0, en_i = 1'b0, mode_i = 1'b0;
  logic [3:0] b_i = '0;
  logic [3:0] y_o, y1_o;
  logic       win_o, lose_o, over_o, win1_o, lose1_o, over1_o;
  logic [3:0] score_o;
  logic       score1_o;
  logic [2:0] lives_o, lives1_o;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  guess_game_n dut (
    .clk(clk), .reset(rst_i), .en(en_i), .mode(mode_i), .b(b_i), .y(y_o),
    .win(win_o), .lose(lose_o), .over(over_o), .score(score_o), .lives_left(lives_o)
  );

  guess_game_n #(.N(4), .SCORE_W(1), .LIVES(3)) dut1 (
    .clk(clk), .reset(rst_i), .en(en_i), .mode(mode_i), .b(b_i), .y(y1_o),
    .win(win1_o), .lose(lose1_o), .over(over1_o), .score(score1_o), .lives_left(lives1_o)
  );

  typedef struct {
    bit rst, en, mode;
    logic [3:0] b, y;
    bit w, l, o;
    logic [3:0] sc;
    logic sc1;
    logic [2:0] lv;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input bit r, input bit e, input bit m, input logic [3:0] bb);
    rst_i = r; en_i = e; mode_i = m; b_i = bb;
    @(negedge clk);
  endtask

  initial begin
    //              rst en md b     y    w l o sc  s1 lv
    v.push_back('{1, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 0, 4'h0, 4'h2, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 0, 4'h0, 4'h4, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 0, 4'h0, 4'h8, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 0, 4'h0, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h2, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h4, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h8, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h4, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h2, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h2, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h0, 4'h4, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 1, 1, 4'h4, 4'hF, 1, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 1, 1, 4'h4, 4'hF, 1, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 0, 1, 4'h0, 4'h1, 0, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 1, 0, 4'h0, 4'h2, 0, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 0, 0, 4'h3, 4'h0, 0, 1, 0, 4'd1, 1, 3'd2});
    v.push_back('{0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd1, 1, 3'd2});
    v.push_back('{0, 0, 0, 4'h8, 4'h0, 0, 1, 0, 4'd1, 1, 3'd1});
    v.push_back('{0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd1, 1, 3'd1});
    v.push_back('{0, 0, 0, 4'h8, 4'h0, 0, 1, 0, 4'd1, 1, 3'd0});
    v.push_back('{0, 1, 0, 4'h8, 4'h0, 0, 1, 0, 4'd1, 1, 3'd0});
    v.push_back('{0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 4'd1, 1, 3'd0});
    v.push_back('{0, 1, 1, 4'h1, 4'h0, 0, 1, 1, 4'd1, 1, 3'd0});
    v.push_back('{0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 4'd1, 1, 3'd0});
    v.push_back('{1, 0, 0, 4'h1, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 0, 0, 4'h1, 4'hF, 1, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 0, 0, 4'h1, 4'hF, 1, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{1, 0, 0, 4'h1, 4'h1, 0, 0, 0, 4'd0, 0, 3'd3});
    v.push_back('{0, 0, 0, 4'h1, 4'hF, 1, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd1, 1, 3'd3});
    v.push_back('{0, 0, 0, 4'h1, 4'hF, 1, 0, 0, 4'd2, 1, 3'd3});
    v.push_back('{0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 4'd2, 1, 3'd3});
    @(negedge clk);
    foreach (v[i]) begin
      drive(v[i].rst, v[i].en, v[i].mode, v[i].b);
      chk("y", i, 32'(y_o), 32'(v[i].y));
      chk("win", i, 32'(win_o), 32'(v[i].w));
      chk("lose", i, 32'(lose_o), 32'(v[i].l));
      chk("over", i, 32'(over_o), 32'(v[i].o));
      chk("score", i, 32'(score_o), 32'(v[i].sc));
      chk("lives", i, 32'(lives_o), 32'(v[i].lv));
      chk("score_w1", i, 32'(score1_o), 32'(v[i].sc1));
      chk("y_w1", i, 32'(y1_o), 32'(v[i].y));
    end
    // outputs must not react to b before the clock edge
    drive(1, 0, 0, 4'h0);
    b_i = 4'hF; en_i = 1'b1;
    #1;
    chk("nocomb_y", 0, 32'(y_o), 32'h1);
    chk("nocomb_win", 0, 32'(win_o), 32'h0);
    chk("nocomb_lose", 0, 32'(lose_o), 32'h0);
    b_i = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, 0, 4'h0);
      chk("wrap_run", k, 32'(y_o), 32'(4'h1 << (k % 4)));
    end
    drive(0, 0, 1, 4'h0);
    chk("mode_switch_hold", 0, 32'(y_o), 32'h2);
    drive(0, 1, 1, 4'h0);
    chk("mode_switch_adv", 0, 32'(y_o), 32'h4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
